// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the fetch PC, issues one-at-a-time word requests
// to instruction memory, and queues {pc, instr} for decode. Optional FETCH_ALIGN_CHECK_EN.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          QDEPTH   = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  input  logic        out_ready,
  output logic        fault
);

  localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(QDEPTH);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  entry_t          mem_q [QDEPTH];
  entry_t          mem_d [QDEPTH];
  logic [PW-1:0]   rd_q, rd_d;
  logic [PW-1:0]   wr_q, wr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [31:0]     fetch_pc_q, fetch_pc_d;
  logic            req_q, req_d;
  logic [31:0]     addr_q, addr_d;
  logic            discard_q, discard_d;
  logic            fetch_blocked;
  logic            ack_valid;
  logic            push;
  logic            pop;
  logic [31:0]     target_pc;

`ifdef FETCH_ALIGN_CHECK_EN
  logic            fault_q, fault_d;
`else
  logic            unused_redirect_lsbs;
  assign unused_redirect_lsbs = ^redirect_pc[1:0];
`endif

  assign target_pc = {redirect_pc[31:2], 2'b00};
  assign ack_valid = req_q && imem_ack;
  assign pop       = (count_q != '0) && out_ready;

  // NOTE: combinational next-state uses blocking '='; only the always_ff below uses '<='.
  always_comb begin
    mem_d      = mem_q;
    rd_d       = rd_q;
    wr_d       = wr_q;
    count_d    = count_q;
    fetch_pc_d = fetch_pc_q;
    req_d      = req_q;
    addr_d     = addr_q;
    discard_d  = discard_q;
    push       = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
    fault_d    = fault_q;
`endif

    if (redirect) begin
      // Redirect wins: flush the queue, drop any data arriving now, and mark a
      // still-pending request so its data is dropped when it eventually returns.
      rd_d       = '0;
      wr_d       = '0;
      count_d    = '0;
      fetch_pc_d = target_pc;
      discard_d  = req_q && !imem_ack;
`ifdef FETCH_ALIGN_CHECK_EN
      fault_d    = (redirect_pc[1:0] != 2'b00);
`endif
    end else begin
      if (ack_valid) begin
        if (discard_q) begin
          discard_d = 1'b0;
        end else begin
          push       = 1'b1;
          fetch_pc_d = addr_q + 32'd4;
        end
      end
      if (push) begin
        mem_d[wr_q] = '{pc: addr_q, instr: imem_rdata};
        wr_d        = wr_q + 1'b1;
      end
      if (pop) begin
        rd_d = rd_q + 1'b1;
      end
      if (push && !pop) begin
        count_d = count_q + 1'b1;
      end else if (pop && !push) begin
        count_d = count_q - 1'b1;
      end
    end

`ifdef FETCH_ALIGN_CHECK_EN
    fetch_blocked = fault_d;
`else
    fetch_blocked = 1'b0;
`endif

    // A pending request holds address and strobe until acked; otherwise a new
    // request is launched whenever the queue will still have room.
    if (req_q && !imem_ack) begin
      req_d  = 1'b1;
      addr_d = addr_q;
    end else begin
      req_d  = (count_d < DEPTH_C) && !fetch_blocked;
      addr_d = fetch_pc_d;
    end
  end

  // NOTE: queue storage is reset along with the pointers so out_instr/out_pc read 0 after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < QDEPTH; i++) begin
        mem_q[i] <= '0;
      end
      rd_q       <= '0;
      wr_q       <= '0;
      count_q    <= '0;
      fetch_pc_q <= RESET_PC;
      req_q      <= 1'b0;
      addr_q     <= RESET_PC;
      discard_q  <= 1'b0;
    end else begin
      mem_q      <= mem_d;
      rd_q       <= rd_d;
      wr_q       <= wr_d;
      count_q    <= count_d;
      fetch_pc_q <= fetch_pc_d;
      req_q      <= req_d;
      addr_q     <= addr_d;
      discard_q  <= discard_d;
    end
  end

`ifdef FETCH_ALIGN_CHECK_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      fault_q <= 1'b0;
    end else begin
      fault_q <= fault_d;
    end
  end
  assign fault = fault_q;
`else
  assign fault = 1'b0;
`endif

  assign imem_req  = req_q;
  assign imem_addr = addr_q;
  assign out_valid = (count_q != '0);
  assign out_instr = mem_q[rd_q].instr;
  assign out_pc    = mem_q[rd_q].pc;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit; memory returns ~addr as the
// instruction word and acks in the same cycle as the request when enabled.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        out_ready;
  logic        fault;
  logic        ack_en;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  assign imem_ack   = imem_req & ack_en;
  assign imem_rdata = imem_ack ? ~imem_addr : 32'h0;

  fetch_unit #(.RESET_PC(32'h0000_0000), .QDEPTH(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .out_valid  (out_valid),
    .out_instr  (out_instr),
    .out_pc     (out_pc),
    .out_ready  (out_ready),
    .fault      (fault)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst         = 1'b1;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    out_ready   = 1'b0;
    ack_en      = 1'b0;
    step();
    step();
  endtask

  initial begin
    // Reset state
    do_reset();
    check("rst_req",   {31'h0, imem_req},  32'h0);
    check("rst_addr",  imem_addr,          32'h0);
    check("rst_valid", {31'h0, out_valid}, 32'h0);
    check("rst_instr", out_instr,          32'h0);
    check("rst_pc",    out_pc,             32'h0);
    check("rst_fault", {31'h0, fault},     32'h0);

    // Streaming with zero-wait memory: one instruction per cycle, no gaps
    rst = 1'b0; ack_en = 1'b1; out_ready = 1'b1;
    check("first_req_wait", {31'h0, imem_req}, 32'h0);
    step();
    check("first_req",  {31'h0, imem_req}, 32'h1);
    check("first_addr", imem_addr,         32'h0);
    step();
    for (int i = 0; i < 6; i++) begin
      check("stream_valid", {31'h0, out_valid}, 32'h1);
      check("stream_pc",    out_pc,             32'(4 * i));
      check("stream_instr", out_instr,          ~32'(4 * i));
      step();
    end

    // Backpressure from the start: two entries fill the queue, then fetch stops
    do_reset();
    rst = 1'b0; ack_en = 1'b1; out_ready = 1'b0;
    step();
    step();
    step();
    check("full_req",   {31'h0, imem_req},  32'h0);
    check("full_valid", {31'h0, out_valid}, 32'h1);
    check("full_pc",    out_pc,             32'h0);
    step();
    check("hold_pc",    out_pc,             32'h0);
    check("hold_instr", out_instr,          ~32'h0);
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      check("drain_valid", {31'h0, out_valid}, 32'h1);
      check("drain_pc",    out_pc,             32'(4 * k));
      step();
    end

    // Idle redirect: fill queue so nothing is pending, then redirect to 0x40
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) step();
    check("idle_req", {31'h0, imem_req}, 32'h0);
    redirect = 1'b1; redirect_pc = 32'h40;
    step();
    redirect = 1'b0; out_ready = 1'b1;
    check("idle_rd_valid", {31'h0, out_valid}, 32'h0);
    check("idle_rd_req",   {31'h0, imem_req},  32'h1);
    check("idle_rd_addr",  imem_addr,          32'h40);
    step();
    check("idle_rd_outv",  {31'h0, out_valid}, 32'h1);
    check("idle_rd_pc",    out_pc,             32'h40);
    check("idle_rd_instr", out_instr,          ~32'h40);

    // Redirect while request to 0x8 is pending with a delayed ack
    do_reset();
    rst = 1'b0; out_ready = 1'b1; ack_en = 1'b0;
    step();
    ack_en = 1'b1;
    step();
    step();
    ack_en = 1'b0;
    check("pend_req",  {31'h0, imem_req}, 32'h1);
    check("pend_addr", imem_addr,         32'h8);
    redirect = 1'b1; redirect_pc = 32'h40;
    step();
    redirect = 1'b0;
    check("pend_flush", {31'h0, out_valid}, 32'h0);
    check("pend_hold0", imem_addr,          32'h8);
    step();
    check("pend_hold1", imem_addr,          32'h8);
    step();
    check("pend_hold2", imem_addr,          32'h8);
    check("pend_hreq",  {31'h0, imem_req},  32'h1);
    ack_en = 1'b1;
    step();
    check("pend_drop",  {31'h0, out_valid}, 32'h0);
    check("pend_next",  imem_addr,          32'h40);
    step();
    check("pend_outv",  {31'h0, out_valid}, 32'h1);
    check("pend_pc",    out_pc,             32'h40);
    check("pend_instr", out_instr,          ~32'h40);

    // Wrap of the address space; ack coinciding with redirect is dropped
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    step();
    redirect = 1'b0;
    check("wrap_flush", {31'h0, out_valid}, 32'h0);
    check("wrap_addr",  imem_addr,          32'hFFFF_FFFC);
    step();
    check("wrap_pc0",   out_pc,             32'hFFFF_FFFC);
    check("wrap_ins0",  out_instr,          32'h0000_0003);
    step();
    check("wrap_pc1",   out_pc,             32'h0);
    check("wrap_ins1",  out_instr,          32'hFFFF_FFFF);

    // Misaligned redirect
    redirect = 1'b1; redirect_pc = 32'h42;
    step();
    redirect = 1'b0;
    check("mis_valid", {31'h0, out_valid}, 32'h0);
`ifdef FETCH_ALIGN_CHECK_EN
    check("mis_fault", {31'h0, fault},    32'h1);
    check("mis_req",   {31'h0, imem_req}, 32'h0);
    step();
    check("mis_fault1", {31'h0, fault},    32'h1);
    check("mis_req1",   {31'h0, imem_req}, 32'h0);
    redirect = 1'b1; redirect_pc = 32'h80;
    step();
    redirect = 1'b0;
    check("clr_fault", {31'h0, fault}, 32'h0);
    check("clr_addr",  imem_addr,      32'h80);
    step();
    check("clr_pc",    out_pc,         32'h80);
`else
    check("mis_fault", {31'h0, fault}, 32'h0);
    check("mis_addr",  imem_addr,      32'h40);
    step();
    check("mis_outv",  {31'h0, out_valid}, 32'h1);
    check("mis_pc",    out_pc,             32'h40);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction-fetch stage feeding decode/ALU in the MIPS core. Owns the fetch PC, issues word requests to instruction_memory over a req/ack handshake, and buffers returned instructions in a small queue. Presents {instr, pc} downstream with a valid/ready handshake, and accepts a redirect from decode/execute for branches and jumps.

Parameters:
RESET_PC, 32'h0000_0000, fetch address after reset
QDEPTH, 2, instruction queue depth; power of two, >= 2

Ports:
clk  in  1  clock
rst  in  1  reset
imem_req  out  1  fetch request to instruction memory
imem_addr  out  32  word address of request; low 2 bits always 00
imem_ack  in  1  memory returns data this cycle for the pending request
imem_rdata  in  32  instruction data, valid when imem_ack=1
redirect  in  1  flush and restart fetch at redirect_pc
redirect_pc  in  32  new fetch address (branch/jump target)
out_valid  out  1  queue head valid
out_instr  out  32  instruction at queue head
out_pc  out  32  PC of out_instr
out_ready  in  1  downstream accepts head this cycle
fault  out  1  misaligned redirect (optional feature only; otherwise tied 0)

Behaviour:
- Reset is synchronous, active-high on rst; clock is clk. After reset: fetch_pc=RESET_PC, queue empty, imem_req=0, imem_addr=RESET_PC, out_valid=0, out_instr=0, out_pc=0, fault=0, discard flag=0. First imem_req is in the cycle after rst deasserts.
- Reset mid-operation: all state cleared at the next edge; any pending request is abandoned (memory is reset by the same rst).
- Requests: at most one outstanding. imem_req is a registered output. It rises when no request is pending and count < QDEPTH. Once raised, imem_req and imem_addr hold stable until the cycle imem_ack=1. imem_ack while imem_req=0 is ignored.
- On ack (no discard): push {imem_addr, imem_rdata}; fetch_pc <= imem_addr+4 (mod 2^32, wraps FFFFFFFC->0).
- Back-to-back requests: if space remains after the push, imem_req stays high next cycle with the address +4. Throughput is 1 instr/cycle with a zero-wait memory.
- Queue: FIFO, registered storage. out_* are driven from the head. out_valid = (count != 0). A pop occurs when out_valid && out_ready. Push and pop may happen in the same cycle; the count is then unchanged.
- out_instr and out_pc hold stable while out_valid && !out_ready.
- Redirect has priority over every other event in its cycle:
  - The queue is cleared, so out_valid=0 next cycle. A handshake in the same cycle still counts as delivered.
  - fetch_pc <= redirect_pc.
  - If a request is pending without ack, imem_req/imem_addr keep holding until ack. The discard flag is set and the returned data is dropped (no push). The next request uses the redirect target.
  - If imem_ack coincides with redirect, that data is dropped.
  - Multiple redirects before ack: the last one wins.
- Latency: redirect at cycle N with nothing pending -> imem_req with redirect_pc at N+1; ack at N+1 -> out_valid with that instr at N+2.
- A full queue blocks new requests; fetch never overwrites unconsumed entries.

Optional Feature:
FETCH_ALIGN_CHECK_EN
- Defined: redirect with redirect_pc[1:0] != 00 sets fault=1 (sticky) and flushes the queue. No new requests are issued; a pending request completes and is discarded. A later aligned redirect clears fault and resumes fetch there; rst also clears fault.
- Undefined: redirect_pc[1:0] is forced to 00, fault is tied 0, and no checking logic is present.

Test Plan:
- Reset, out_ready=1, ack in the cycle after each req -> out_pc 0,4,8,C... with out_instr equal to memory words; no gaps once streaming.
- out_ready=0 from start -> after 2 pushes, imem_req=0 and head holds pc 0; raise out_ready -> pc 0,4,8 delivered, none lost or duplicated.
- Idle redirect to 0x40 at cycle N -> out_valid=0 at N+1, imem_addr=0x40 at N+1, out_pc=0x40 at N+2.
- Request to 0x8 pending, ack delayed 3 cycles, redirect to 0x40 -> imem_addr holds 0x8 until ack, data dropped, next req 0x40, first out_pc 0x40.
- Redirect to 0xFFFFFFFC -> out_pc 0xFFFFFFFC then 0x00000000.
- With FETCH_ALIGN_CHECK_EN: redirect 0x42 -> fault=1, imem_req stays 0; redirect 0x80 -> fault=0, first out_pc 0x80. Without the macro: redirect 0x42 -> first out_pc 0x40.
